// File: rtl/mda_colour_ctrl.sv
// Colour-select controller for the MDA HDMI stage: debounced switches, frame-aligned
// colour changes, a post-change video mute, and a vsync watchdog for sourceless operation.
module mda_colour_ctrl #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int MUTE_FRAMES   = 2,
  parameter int TIMEOUT_BITS  = 22,
  parameter bit VSYNC_POL     = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       vsync,
  output logic [1:0] sw_stable,
  output logic [1:0] colour_sel,
  output logic       video_mute,
  output logic       sel_update
);

  typedef enum logic [1:0] {IDLE, PEND, MUTE} state_t;

  localparam logic [DEBOUNCE_BITS-1:0] D_MAX = '1;
  localparam logic [DEBOUNCE_BITS-1:0] D_ONE = 1;
  localparam logic [TIMEOUT_BITS-1:0]  W_ONE = 1;
  localparam logic [3:0]               MF    = 4'(MUTE_FRAMES);

  state_t                   state;
  logic [1:0]               s1, s2, cand;
  logic [DEBOUNCE_BITS-1:0] dcnt;
  logic                     vs_q;
  logic [TIMEOUT_BITS-1:0]  wcnt;
  logic [3:0]               mcnt;
  logic                     frame_start, wd_fire, tick;

  assign frame_start = (vsync == VSYNC_POL) && (vs_q != VSYNC_POL);
  assign wd_fire     = &wcnt;
  assign tick        = frame_start | wd_fire;

  // Two-flop synchroniser feeding a restart-on-change debounce counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= 2'b00;
      s2        <= 2'b00;
      cand      <= 2'b00;
      dcnt      <= '0;
      sw_stable <= 2'b00;
      vs_q      <= 1'b0;
    end else begin
      s1   <= {switch2, switch3};
      s2   <= s1;
      vs_q <= vsync;
      if (s2 != cand) begin
        cand <= s2;
        dcnt <= '0;
      end else if (dcnt != D_MAX) begin
        dcnt <= dcnt + D_ONE;
      end
      if (dcnt == D_MAX) sw_stable <= cand;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      colour_sel <= 2'b00;
      video_mute <= 1'b0;
      sel_update <= 1'b0;
      wcnt       <= '0;
      mcnt       <= 4'd0;
    end else begin
      sel_update <= 1'b0;
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (sw_stable != colour_sel) state <= PEND;
        end
        PEND: begin
          if (tick) begin
            wcnt <= '0;
            if (sw_stable == colour_sel) begin
              state <= IDLE;
            end else begin
              colour_sel <= sw_stable;
              sel_update <= 1'b1;
              mcnt       <= MF;
              if (MF == 4'd0) begin
                state <= IDLE;
              end else begin
                video_mute <= 1'b1;
                state      <= MUTE;
              end
            end
          end else begin
            wcnt <= wcnt + W_ONE;
          end
        end
        MUTE: begin
          // Watchdog wins so a dead source can never leave the output blanked.
          if (wd_fire) begin
            wcnt       <= '0;
            video_mute <= 1'b0;
            state      <= IDLE;
          end else if (frame_start) begin
            wcnt <= '0;
            if (mcnt <= 4'd1) begin
              mcnt       <= 4'd0;
              video_mute <= 1'b0;
              state      <= IDLE;
            end else begin
              mcnt <= mcnt - 4'd1;
            end
          end else begin
            wcnt <= wcnt + W_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mda_colour_ctrl.sv
// Randomised bench for mda_colour_ctrl against a windowed-stability / frame-event reference model.
module tb_mda_colour_ctrl;

  localparam int DB  = 4;
  localparam int WIN = 1 << DB;           // consecutive equal pin samples to accept
  localparam int TO  = (1 << 8) - 1;      // watchdog terminal count
  localparam int MFR = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] sw;
  logic       vsync;
  logic [1:0] sw_stable, colour_sel;
  logic       video_mute, sel_update;

  logic vs_en, chk_en;
  int   n_run = 0, n_fail = 0;

  mda_colour_ctrl #(
    .DEBOUNCE_BITS(DB), .MUTE_FRAMES(MFR), .TIMEOUT_BITS(8), .VSYNC_POL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .switch2(sw[1]), .switch3(sw[0]), .vsync(vsync),
    .sw_stable(sw_stable), .colour_sel(colour_sel), .video_mute(video_mute),
    .sel_update(sel_update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin sample history, pending/muted mode, frames left, watchdog age.
  logic [1:0] hist [0:WIN+1];
  logic [1:0] m_stable, m_sel, nst;
  logic       m_mute, m_upd, vs_prev, fs, wd, tk, win;
  int         mode, age, left;   // mode: 0 waiting, 1 change pending, 2 muted

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIN + 2; i++) hist[i] = 2'b00;
      m_stable = 2'b00; m_sel = 2'b00; m_mute = 1'b0; m_upd = 1'b0;
      vs_prev = 1'b0; mode = 0; age = 0; left = 0;
    end else begin
      // hist[j] holds the pin sample j+1 edges ago; acceptance lags the window by 3 edges
      win = 1'b1;
      for (int j = 3; j < WIN + 2; j++) if (hist[j] != hist[2]) win = 1'b0;
      nst = win ? hist[2] : m_stable;
      for (int i = WIN + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw;

      fs = vsync && !vs_prev;
      vs_prev = vsync;
      wd = (mode != 0) && (age == TO);
      tk = fs || wd;
      m_upd = 1'b0;
      if (mode == 0) begin
        age = 0;
        if (m_stable != m_sel) mode = 1;
      end else if (mode == 1) begin
        if (tk) begin
          age = 0;
          if (m_stable == m_sel) mode = 0;
          else begin
            m_sel = m_stable; m_upd = 1'b1; left = MFR;
            if (MFR == 0) mode = 0;
            else begin m_mute = 1'b1; mode = 2; end
          end
        end else age++;
      end else begin
        if (wd) begin
          age = 0; m_mute = 1'b0; mode = 0;
        end else if (fs) begin
          age = 0; left--;
          if (left == 0) begin m_mute = 1'b0; mode = 0; end
        end else age++;
      end
      m_stable = nst;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sw_stable",  {30'd0, sw_stable},  {30'd0, m_stable});
      chk("colour_sel", {30'd0, colour_sel}, {30'd0, m_sel});
      chk("video_mute", {31'd0, video_mute}, {31'd0, m_mute});
      chk("sel_update", {31'd0, sel_update}, {31'd0, m_upd});
    end
  end

  initial begin
    vsync = 1'b0;
    forever begin
      @(negedge clk);
      if (vs_en) begin
        repeat ($urandom_range(30, 250)) @(negedge clk);
        vsync = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        vsync = 1'b0;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_sw_stable"},  {30'd0, sw_stable},  32'd0);
    chk({tag, "_colour_sel"}, {30'd0, colour_sel}, 32'd0);
    chk({tag, "_video_mute"}, {31'd0, video_mute}, 32'd0);
    chk({tag, "_sel_update"}, {31'd0, sel_update}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [1:0] orig;
    reset_n = 1'b0; sw = 2'b00; vs_en = 1'b0; chk_en = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Debounce latency from a clean pin edge, no vsync running
    sw = 2'b10;
    n = 0;
    while (sw_stable !== 2'b10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("deb_latency", n, 19);
    chk("sel_before_tick", {30'd0, colour_sel}, 32'd0);

    for (int seg = 0; seg < 160; seg++) begin
      vs_en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0: do_reset();
        1, 2, 3, 4: begin
          orig = sw;
          sw = orig ^ 2'($urandom_range(1, 3));
          repeat ($urandom_range(1, WIN - 2)) @(negedge clk);
          sw = orig;
          repeat ($urandom_range(5, 60)) @(negedge clk);
        end
        default: begin
          sw = 2'($urandom_range(0, 3));
          repeat ($urandom_range(20, 400)) @(negedge clk);
        end
      endcase
    end
    // Final long quiet stretch lets any pending or muted sequence drain by watchdog
    vs_en = 1'b0;
    repeat (700) @(negedge clk);
    chk("drain_mute", {31'd0, video_mute}, 32'd0);
    chk("drain_sel", {30'd0, colour_sel}, {30'd0, m_stable});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
